// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch prediction unit.
// Index and tag extraction are written for PCs up to 64 bits wide.
package bpu_pkg;

    localparam logic [1:0] CNT_WEAK_T  = 2'b10;
    localparam logic [1:0] CNT_WEAK_NT = 2'b01;

    typedef struct packed {
        logic        valid;
        logic [63:0] tag;
        logic [63:0] target;
        logic        is_jmp;
    } btb_entry_t;

    function automatic int unsigned idx_of(logic [63:0] pc, int unsigned idx_w);
        return 32'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
    endfunction

    function automatic logic [63:0] tag_of(logic [63:0] pc, int unsigned idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// One BHT entry: saturating up/down counter that resets to weak-not-taken
// and loads weak-taken on allocation. Priority is init > inc > dec.
module bht_sat_counter
    import bpu_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(CNT_WEAK_T) << (CNT_W - 2);
    localparam logic [CNT_W-1:0] WEAK_NT = WEAK_T - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= WEAK_NT;
        end else if (init) begin
            cnt <= WEAK_T;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch PC register with direct-mapped BTB + 2-bit BHT; predicts at IF, resolves at EXE.
// Optional BPU_PERF_CNT_EN adds trained-instruction and mispredict counters.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter int              BTB_ENTRIES = 16,
    parameter int              CNT_W       = 2,
    parameter logic [XLEN-1:0] RESET_VEC   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_if,
    output logic [XLEN-1:0] pc_if,
    output logic            pred_taken_if,
    output logic [XLEN-1:0] pred_pc_if,
    input  logic            exe_valid,
    input  logic            exe_is_br,
    input  logic            exe_is_jmp,
    input  logic [XLEN-1:0] exe_pc,
    input  logic            exe_taken,
    input  logic [XLEN-1:0] exe_target,
    input  logic [XLEN-1:0] exe_pred_pc,
    output logic            mispredict
`ifdef BPU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_br_cnt,
    output logic [31:0]     perf_miss_cnt
`endif
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    btb_entry_t       btb [BTB_ENTRIES];
    logic [CNT_W-1:0] cnt [BTB_ENTRIES];
    logic [XLEN-1:0]  pc_q;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             if_hit;
    logic             ex_hit;
    logic [XLEN-1:0]  true_pc;
    logic             train;
    logic             alloc;
    logic             alias_clr;

    assign pc_if  = pc_q;
    assign if_idx = IDX_W'(idx_of(64'(pc_q), IDX_W));
    assign ex_idx = IDX_W'(idx_of(64'(exe_pc), IDX_W));
    assign if_hit = btb[if_idx].valid && (btb[if_idx].tag == tag_of(64'(pc_q), IDX_W));
    assign ex_hit = btb[ex_idx].valid && (btb[ex_idx].tag == tag_of(64'(exe_pc), IDX_W));

    assign pred_taken_if = if_hit && (btb[if_idx].is_jmp || cnt[if_idx][CNT_W-1]);
    assign pred_pc_if    = pred_taken_if ? btb[if_idx].target[XLEN-1:0] : pc_q + XLEN'(4);

    assign true_pc    = exe_taken ? exe_target : exe_pc + XLEN'(4);
    assign mispredict = exe_valid && (true_pc != exe_pred_pc);

    assign train     = exe_valid && (exe_is_br || exe_is_jmp);
    assign alloc     = train && !ex_hit && exe_taken;
    // A non-control instruction that was predicted taken hit a stale alias.
    assign alias_clr = exe_valid && !exe_is_br && !exe_is_jmp && mispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else if (mispredict) begin
            pc_q <= true_pc;
        end else if (!stall_if) begin
            pc_q <= pred_pc_if;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i].valid <= 1'b0;
            end
        end else begin
            if (train && ex_hit && exe_taken) begin
                btb[ex_idx].target <= 64'(exe_target);
            end
            if (alloc) begin
                btb[ex_idx] <= '{valid:  1'b1,
                                 tag:    tag_of(64'(exe_pc), IDX_W),
                                 target: 64'(exe_target),
                                 is_jmp: exe_is_jmp};
            end
            if (alias_clr) begin
                btb[ex_idx].valid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < BTB_ENTRIES; g++) begin : g_bht
        logic sel;
        assign sel = (ex_idx == IDX_W'(g));
        bht_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .init (alloc && sel),
            .inc  (train && ex_hit && exe_taken && sel),
            .dec  (train && ex_hit && !exe_taken && sel),
            .cnt  (cnt[g])
        );
    end

`ifdef BPU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_cnt   <= '0;
            perf_miss_cnt <= '0;
        end else begin
            perf_br_cnt   <= perf_br_cnt + 32'(train);
            perf_miss_cnt <= perf_miss_cnt + 32'(mispredict);
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed scenarios plus random EXE traffic
// checked against a table-level reference model of the BTB/BHT rules.
module tb_branch_predict_unit;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_if = 1'b0;
    logic [63:0] pc_if;
    logic        pred_taken_if;
    logic [63:0] pred_pc_if;
    logic        exe_valid = 1'b0;
    logic        exe_is_br = 1'b0;
    logic        exe_is_jmp = 1'b0;
    logic [63:0] exe_pc = '0;
    logic        exe_taken = 1'b0;
    logic [63:0] exe_target = '0;
    logic [63:0] exe_pred_pc = '0;
    logic        mispredict;
`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_miss_cnt;
`endif

    always #5 clk = ~clk;

    branch_predict_unit #(.XLEN(64), .BTB_ENTRIES(N), .CNT_W(2), .RESET_VEC(64'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .pc_if         (pc_if),
        .pred_taken_if (pred_taken_if),
        .pred_pc_if    (pred_pc_if),
        .exe_valid     (exe_valid),
        .exe_is_br     (exe_is_br),
        .exe_is_jmp    (exe_is_jmp),
        .exe_pc        (exe_pc),
        .exe_taken     (exe_taken),
        .exe_target    (exe_target),
        .exe_pred_pc   (exe_pred_pc),
        .mispredict    (mispredict)
`ifdef BPU_PERF_CNT_EN
        ,
        .perf_br_cnt   (perf_br_cnt),
        .perf_miss_cnt (perf_miss_cnt)
`endif
    );

    // Reference model: the BTB as plain arrays indexed by (pc/4) mod N.
    bit          m_valid [N];
    logic [63:0] m_tag   [N];
    logic [63:0] m_tgt   [N];
    bit          m_jmp   [N];
    int          m_cnt   [N];
    logic [63:0] m_pc;
    bit          m_known = 1'b0;
    int unsigned m_br = 0;
    int unsigned m_miss = 0;

    typedef struct {
        bit          known;
        logic [63:0] pc;
        bit          pt;
        logic [63:0] ppc;
        bit          mis;
        int unsigned br;
        int unsigned miss;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int m_idx(logic [63:0] pc);
        return int'((pc >> 2) % 64'(N));
    endfunction

    function automatic logic [63:0] m_tagv(logic [63:0] pc);
        return pc / 64'(4 * N);
    endfunction

    function automatic bit m_ptaken(logic [63:0] pc);
        int i = m_idx(pc);
        return m_valid[i] && (m_tag[i] == m_tagv(pc)) && (m_jmp[i] || m_cnt[i] >= 2);
    endfunction

    function automatic logic [63:0] m_ppc(logic [63:0] pc);
        return m_ptaken(pc) ? m_tgt[m_idx(pc)] : pc + 64'd4;
    endfunction

    // One clock cycle: drive inputs, queue the expected response, advance the model.
    task automatic cyc(input bit r, input bit st, input bit v, input bit br, input bit jmp,
                       input logic [63:0] epc, input bit tk, input logic [63:0] etgt,
                       input logic [63:0] eppc);
        exp_t        e;
        logic [63:0] tp;
        logic [63:0] nxt;
        int          i;
        bit          hit;
        bit          trn;
        rst = r; stall_if = st; exe_valid = v; exe_is_br = br; exe_is_jmp = jmp;
        exe_pc = epc; exe_taken = tk; exe_target = etgt; exe_pred_pc = eppc;
        tp = tk ? etgt : epc + 64'd4;
        e.known = m_known;
        e.pc    = m_pc;
        e.pt    = m_known ? m_ptaken(m_pc) : 1'b0;
        e.ppc   = m_known ? m_ppc(m_pc) : '0;
        e.mis   = v && (tp != eppc);
        e.br    = m_br;
        e.miss  = m_miss;
        q.push_back(e);
        nxt = e.mis ? tp : (st ? m_pc : e.ppc);
        if (r) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 1'b0;
                m_cnt[k]   = 1;
            end
            m_pc = 64'h0; m_known = 1'b1; m_br = 0; m_miss = 0;
        end else begin
            i   = m_idx(epc);
            hit = m_valid[i] && (m_tag[i] == m_tagv(epc));
            trn = v && (br || jmp);
            if (trn && hit) begin
                m_cnt[i] = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                              : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
                if (tk) m_tgt[i] = etgt;
            end else if (trn && tk) begin
                m_valid[i] = 1'b1; m_tag[i] = m_tagv(epc); m_tgt[i] = etgt;
                m_jmp[i] = jmp; m_cnt[i] = 2;
            end
            if (v && !br && !jmp && e.mis) m_valid[i] = 1'b0;
            if (trn) m_br++;
            if (e.mis) m_miss++;
            m_pc = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit st);
        cyc(1'b0, st, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
    endtask

    // Non-control instruction whose fall-through disagrees with its prediction.
    task automatic redirect(input logic [63:0] t);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, t - 64'd4, 1'b0, 64'h0, t + 64'd4);
    endtask

    task automatic branch(input logic [63:0] pc, input bit tk, input logic [63:0] tgt,
                          input logic [63:0] ppc);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, pc, tk, tgt, ppc);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.known) begin
                    check("sb_pc_if", pc_if, e.pc);
                    check("sb_pred_taken", 64'(pred_taken_if), 64'(e.pt));
                    check("sb_pred_pc", pred_pc_if, e.ppc);
                end
                check("sb_mispredict", 64'(mispredict), 64'(e.mis));
`ifdef BPU_PERF_CNT_EN
                if (e.known) begin
                    check("sb_perf_br", 64'(perf_br_cnt), 64'(e.br));
                    check("sb_perf_miss", 64'(perf_miss_cnt), 64'(e.miss));
                end
`endif
            end
        end
    end

    logic [63:0] pc_pool [6] = '{64'h100, 64'h140, 64'h104, 64'h1000,
                                 64'hFFFF_FFFF_FFFF_FFFC, 64'h13C};
    logic [63:0] tg_pool [4] = '{64'h40, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 64'h2000};

    initial begin : stimulus
        int          drain;
        logic [63:0] epc;
        logic [63:0] etgt;
        logic [63:0] eppc;
        int          kind;
        bit          tk;
        @(posedge clk);
        #1;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
        check("reset_pc", pc_if, 64'h0);
        check("reset_pred_taken", 64'(pred_taken_if), 64'h0);

        branch(64'h100, 1'b1, 64'h40, 64'h104);
        check("cold_redirect_pc", pc_if, 64'h40);
        redirect(64'h100);
        check("refetch_pred_taken", 64'(pred_taken_if), 64'h1);
        check("refetch_pred_pc", pred_pc_if, 64'h40);

        branch(64'h100, 1'b0, 64'h40, 64'h40);
        branch(64'h100, 1'b0, 64'h40, 64'h104);
        redirect(64'h100);
        check("cnt00_pred_pc", pred_pc_if, 64'h104);
        for (int k = 0; k < 3; k++) branch(64'h100, 1'b1, 64'h40, 64'h104);
        redirect(64'h100);
        check("cnt11_pred_taken", 64'(pred_taken_if), 64'h1);
        branch(64'h100, 1'b1, 64'h40, 64'h40);
        branch(64'h100, 1'b0, 64'h40, 64'h40);
        redirect(64'h100);
        check("saturate_pred_taken", 64'(pred_taken_if), 64'h1);

        redirect(64'h140);
        check("tag_miss_pred_pc", pred_pc_if, 64'h144);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h100, 1'b0, 64'h0, 64'h40);
        check("alias_true_pc", pc_if, 64'h104);
        redirect(64'h100);
        check("alias_invalidated", 64'(pred_taken_if), 64'h0);

        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h200, 1'b1, 64'h300, 64'h204);
        check("mispredict_over_stall", pc_if, 64'h300);
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            check("stall_hold", pc_if, 64'h300);
        end

        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h500, 1'b1, 64'h800, 64'h504);
        check("reset_mid_redirect", pc_if, 64'h0);

        branch(64'h400, 1'b0, 64'h0,   64'h404);
        branch(64'h408, 1'b1, 64'h500, 64'h40C);
        branch(64'h410, 1'b0, 64'h0,   64'h414);
        branch(64'h418, 1'b1, 64'h600, 64'h41C);
        branch(64'h420, 1'b0, 64'h0,   64'h424);
`ifdef BPU_PERF_CNT_EN
        check("perf_br_5", 64'(perf_br_cnt), 64'd5);
        check("perf_miss_2", 64'(perf_miss_cnt), 64'd2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
        check("perf_br_reset", 64'(perf_br_cnt), 64'd0);
        check("perf_miss_reset", 64'(perf_miss_cnt), 64'd0);
`endif

        for (int n = 0; n < 600; n++) begin
            epc  = pc_pool[$urandom_range(5)];
            etgt = tg_pool[$urandom_range(3)];
            kind = $urandom_range(2);
            tk   = (kind == 2) ? 1'b1 : 1'($urandom_range(1));
            case ($urandom_range(2))
                0:       eppc = epc + 64'd4;
                1:       eppc = etgt;
                default: eppc = m_ppc(epc);
            endcase
            cyc(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(3) != 0),
                (kind == 1), (kind == 2), epc, tk, etgt, eppc);
        end

        drain = 0;
        while (q.size() > 0 && drain < 5) begin
            @(posedge clk);
            drain++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
